// File: rtl/debounce_bank.sv
// Multi-channel push-button/switch debouncer with a shared sample prescaler.
// Each channel provides a two-flop synchroniser, a consecutive-sample filter, edge strobes and a long-press/auto-repeat strobe.
module debounce_bank #(
   parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
   parameter int SAMPLING_RATE               = 1000,
   parameter int CHANNELS                    = 4,
   parameter int STABLE_SAMPLES              = 4,
   parameter int HOLD_SAMPLES                = 1000,
   parameter int REPEAT_SAMPLES              = 200
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] in,
   output logic [CHANNELS-1:0] out,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic [CHANNELS-1:0] hold,
   output logic                tick
);

   localparam int DIV      = BOARD_CLOCK_FREQUENCY_IN_HZ / SAMPLING_RATE;
   localparam int PW       = $clog2(DIV);
   localparam int SW       = $clog2(STABLE_SAMPLES) + 1;
   localparam int HMAX     = (HOLD_SAMPLES > REPEAT_SAMPLES) ? HOLD_SAMPLES : REPEAT_SAMPLES;
   localparam int HW       = $clog2((HMAX > 0) ? HMAX : 1) + 1;
   localparam int HOLD_END = HOLD_SAMPLES + REPEAT_SAMPLES - 1;

   logic [PW-1:0] pre_count;
   logic          tick_en;
   logic          tick_q;

   assign tick_en = (pre_count == PW'(DIV - 1));
   assign tick    = tick_q;

   // tick is delayed one clock so it lines up with the registered strobes it caused.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_count <= '0;
         tick_q    <= 1'b0;
      end else begin
         tick_q <= tick_en;
         if (tick_en) begin
            pre_count <= '0;
         end else begin
            pre_count <= pre_count + PW'(1);
         end
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic          s1;
      logic          s2;
      logic [SW-1:0] cnt;
      logic [HW-1:0] hcnt;
      logic          out_q;
      logic          rise_q;
      logic          fall_q;
      logic          hold_q;
      logic          flip;

      assign flip    = (s2 != out_q) && (cnt == SW'(STABLE_SAMPLES - 1));
      assign out[i]  = out_q;
      assign rise[i] = rise_q;
      assign fall[i] = fall_q;
      assign hold[i] = hold_q;

      // The hold counter restarts at HOLD_SAMPLES after each repeat so it never exceeds HOLD+REPEAT-1.
      always_ff @(posedge clk) begin
         if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            hcnt   <= '0;
            out_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            hold_q <= 1'b0;
         end else begin
            s1     <= in[i];
            s2     <= s1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            hold_q <= 1'b0;
            if (!out_q) begin
               hcnt <= '0;
            end
            if (tick_en) begin
               if (s2 == out_q) begin
                  cnt <= '0;
               end else if (flip) begin
                  out_q  <= s2;
                  cnt    <= '0;
                  rise_q <= s2;
                  fall_q <= !s2;
                  hcnt   <= '0;
               end else begin
                  cnt <= cnt + SW'(1);
               end
               if (out_q && !flip && HOLD_SAMPLES != 0) begin
                  if (REPEAT_SAMPLES != 0 && int'(hcnt) == HOLD_END) begin
                     hcnt   <= HW'(HOLD_SAMPLES);
                     hold_q <= 1'b1;
                  end else if (int'(hcnt) == HOLD_SAMPLES - 1) begin
                     hcnt   <= hcnt + HW'(1);
                     hold_q <= 1'b1;
                  end else if (int'(hcnt) < HOLD_SAMPLES || REPEAT_SAMPLES != 0) begin
                     hcnt <= hcnt + HW'(1);
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: directed and randomised input sequences compared
// every cycle against a tick-level behavioural model of the debouncer.
module tb_debounce_bank;

   localparam int BOARD  = 1000;
   localparam int SAMPLE = 100;
   localparam int DIV    = BOARD / SAMPLE;
   localparam int CH     = 2;
   localparam int STABLE = 3;
   localparam int HOLDN  = 5;
   localparam int REPN   = 2;

   logic          clk;
   logic          rst;
   logic [CH-1:0] in_sig;
   logic [CH-1:0] out;
   logic [CH-1:0] rise;
   logic [CH-1:0] fall;
   logic [CH-1:0] hold;
   logic          tick;

   int checks   = 0;
   int failures = 0;

   // Reference model state: what a channel "remembers" in terms of samples seen.
   int            edge_count;
   logic          hist_old [CH];
   logic          hist_new [CH];
   logic [CH-1:0] m_out;
   int            streak [CH];
   int            high_ticks [CH];
   logic          exp_tick;
   logic [CH-1:0] exp_rise;
   logic [CH-1:0] exp_fall;
   logic [CH-1:0] exp_hold;

   debounce_bank #(
      .BOARD_CLOCK_FREQUENCY_IN_HZ(BOARD),
      .SAMPLING_RATE(SAMPLE),
      .CHANNELS(CH),
      .STABLE_SAMPLES(STABLE),
      .HOLD_SAMPLES(HOLDN),
      .REPEAT_SAMPLES(REPN)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in(in_sig),
      .out(out),
      .rise(rise),
      .fall(fall),
      .hold(hold),
      .tick(tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model of one clock edge: the input seen at a sample tick is the one applied two edges earlier.
   task automatic modelEdge(input logic r, input logic [CH-1:0] v);
      logic sampled;
      exp_rise = '0;
      exp_fall = '0;
      exp_hold = '0;
      if (r) begin
         edge_count = 0;
         exp_tick   = 1'b0;
         m_out      = '0;
         for (int c = 0; c < CH; c++) begin
            hist_old[c]   = 1'b0;
            hist_new[c]   = 1'b0;
            streak[c]     = 0;
            high_ticks[c] = 0;
         end
      end else begin
         edge_count++;
         exp_tick = (edge_count % DIV == 0);
         for (int c = 0; c < CH; c++) begin
            sampled = hist_old[c];
            if (exp_tick) begin
               if (sampled != m_out[c]) begin
                  streak[c]++;
                  if (streak[c] == STABLE) begin
                     m_out[c]      = sampled;
                     streak[c]     = 0;
                     exp_rise[c]   = sampled;
                     exp_fall[c]   = !sampled;
                     high_ticks[c] = 0;
                  end
               end else begin
                  streak[c] = 0;
               end
               if (m_out[c] && !exp_rise[c]) begin
                  high_ticks[c]++;
                  exp_hold[c] = (high_ticks[c] == HOLDN) ||
                                (REPN > 0 && high_ticks[c] > HOLDN && (high_ticks[c] - HOLDN) % REPN == 0);
               end
            end
            if (!m_out[c]) high_ticks[c] = 0;
            hist_old[c] = hist_new[c];
            hist_new[c] = v[c];
         end
      end
   endtask

   task automatic checkOutput();
      checks++;
      assert (tick === exp_tick) else begin
         failures++;
         $error("[TB] FAIL tick: observed=%0b expected=%0b t=%0t", tick, exp_tick, $time);
      end
      checks++;
      assert (out === m_out) else begin
         failures++;
         $error("[TB] FAIL out: observed=%b expected=%b t=%0t", out, m_out, $time);
      end
      checks++;
      assert (rise === exp_rise) else begin
         failures++;
         $error("[TB] FAIL rise: observed=%b expected=%b t=%0t", rise, exp_rise, $time);
      end
      checks++;
      assert (fall === exp_fall) else begin
         failures++;
         $error("[TB] FAIL fall: observed=%b expected=%b t=%0t", fall, exp_fall, $time);
      end
      checks++;
      assert (hold === exp_hold) else begin
         failures++;
         $error("[TB] FAIL hold: observed=%b expected=%b t=%0t", hold, exp_hold, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then compare just after it.
   task automatic applyStimulus(input logic r, input logic [CH-1:0] v, input int cycles);
      for (int k = 0; k < cycles; k++) begin
         rst    = r;
         in_sig = v;
         @(posedge clk);
         modelEdge(r, v);
         #1;
         checkOutput();
      end
   endtask

   initial begin
      logic [CH-1:0] rv;
      int            remain [CH];
      rst    = 1'b1;
      in_sig = '0;

      $display("[TB] reset and idle");
      applyStimulus(1'b1, 2'b00, 3);
      applyStimulus(1'b0, 2'b00, 40);

      $display("[TB] clean press on channel 0");
      applyStimulus(1'b0, 2'b01, 100);
      applyStimulus(1'b0, 2'b00, 60);

      $display("[TB] bounce on channel 0");
      for (int r = 0; r < 4; r++) begin
         applyStimulus(1'b0, 2'b01, 20);
         applyStimulus(1'b0, 2'b00, 10);
      end
      applyStimulus(1'b0, 2'b00, 50);

      $display("[TB] long press with auto-repeat");
      applyStimulus(1'b0, 2'b01, 200);
      applyStimulus(1'b0, 2'b00, 60);

      $display("[TB] simultaneous press on both channels");
      applyStimulus(1'b0, 2'b11, 60);
      applyStimulus(1'b0, 2'b00, 60);

      $display("[TB] randomised levels");
      rv = '0;
      for (int c = 0; c < CH; c++) remain[c] = 0;
      for (int k = 0; k < 800; k++) begin
         for (int c = 0; c < CH; c++) begin
            if (remain[c] == 0) begin
               rv[c]     = 1'($urandom_range(0, 1));
               remain[c] = $urandom_range(5, 80);
            end
            remain[c]--;
         end
         applyStimulus(1'b0, rv, 1);
      end
      applyStimulus(1'b0, 2'b00, 60);

      $display("[TB] reset during a pending release");
      applyStimulus(1'b0, 2'b01, 60);
      for (int k = 0; k < 100 && streak[0] != 2; k++) applyStimulus(1'b0, 2'b00, 1);
      applyStimulus(1'b1, 2'b00, 1);
      applyStimulus(1'b0, 2'b01, 60);
      applyStimulus(1'b0, 2'b00, 60);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
